// File: rtl/spu_writeback_regfile_if.sv
// Writeback/read-port bundle between the SPU pipe tails, register fetch and the unified register file.
// Write requests and read addresses are always accepted; there is no backpressure.
interface spu_writeback_regfile_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_RD = 6,
  parameter int CNT_W  = 32
);
  logic                           memToReg_1;
  logic                           regWriteEnable_1;
  logic [DATA_W-1:0]              memReadData_1;
  logic [DATA_W-1:0]              result_1;
  logic [ADDR_W-1:0]              registerRT_1;

  logic                           memToReg_2;
  logic                           regWriteEnable_2;
  logic [DATA_W-1:0]              memReadData_2;
  logic [DATA_W-1:0]              result_2;
  logic [ADDR_W-1:0]              registerRT_2;

  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;

  logic [DATA_W-1:0]              wb_data_1;
  logic [DATA_W-1:0]              wb_data_2;
  logic [CNT_W-1:0]               wb_count_1;
  logic [CNT_W-1:0]               wb_count_2;

  modport master (
    output memToReg_1, regWriteEnable_1, memReadData_1, result_1, registerRT_1,
    output memToReg_2, regWriteEnable_2, memReadData_2, result_2, registerRT_2,
    output rd_addr,
    input  rd_data, wb_data_1, wb_data_2, wb_count_1, wb_count_2
  );

  modport slave (
    input  memToReg_1, regWriteEnable_1, memReadData_1, result_1, registerRT_1,
    input  memToReg_2, regWriteEnable_2, memReadData_2, result_2, registerRT_2,
    input  rd_addr,
    output rd_data, wb_data_1, wb_data_2, wb_count_1, wb_count_2
  );
endinterface

// File: rtl/spu_writeback_regfile.sv
// Dual-pipe writeback into the unified register file: 0-cycle wb_data select, 1-cycle write-first reads.
// No backpressure: every enabled write commits; pipe 2 wins same-index collisions (later in program order).
module spu_writeback_regfile #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7,
  parameter int NUM_RD   = 6,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  spu_writeback_regfile_if.slave  wb_if
);

  logic [DATA_W-1:0]              r_regs [NUM_REGS];
  logic [NUM_RD-1:0][DATA_W-1:0]  r_rd_data;
  logic [CNT_W-1:0]               r_wb_count_1;
  logic [CNT_W-1:0]               r_wb_count_2;

  logic [DATA_W-1:0]              w_wb_data_1;
  logic [DATA_W-1:0]              w_wb_data_2;
  logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_bypass;

  assign w_wb_data_1 = wb_if.memToReg_1 ? wb_if.memReadData_1 : wb_if.result_1;
  assign w_wb_data_2 = wb_if.memToReg_2 ? wb_if.memReadData_2 : wb_if.result_2;

  // Pipe 2 is checked last so it overrides pipe 1 when both hit the same index.
  always_comb begin
    w_rd_bypass = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_bypass[k] = r_regs[wb_if.rd_addr[k]];
      if (wb_if.regWriteEnable_1 && (wb_if.registerRT_1 == wb_if.rd_addr[k]))
        w_rd_bypass[k] = w_wb_data_1;
      if (wb_if.regWriteEnable_2 && (wb_if.registerRT_2 == wb_if.rd_addr[k]))
        w_rd_bypass[k] = w_wb_data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_rd_data    <= '0;
      r_wb_count_1 <= '0;
      r_wb_count_2 <= '0;
    end else begin
      if (wb_if.regWriteEnable_1) begin
        r_regs[wb_if.registerRT_1] <= w_wb_data_1;
        r_wb_count_1               <= r_wb_count_1 + CNT_W'(1);
      end
      // Later non-blocking assignment wins, giving pipe 2 priority on a shared index.
      if (wb_if.regWriteEnable_2) begin
        r_regs[wb_if.registerRT_2] <= w_wb_data_2;
        r_wb_count_2               <= r_wb_count_2 + CNT_W'(1);
      end
      r_rd_data <= w_rd_bypass;
    end
  end

  assign wb_if.rd_data    = r_rd_data;
  assign wb_if.wb_data_1  = w_wb_data_1;
  assign wb_if.wb_data_2  = w_wb_data_2;
  assign wb_if.wb_count_1 = r_wb_count_1;
  assign wb_if.wb_count_2 = r_wb_count_2;

endmodule

// File: tb/tb_spu_writeback_regfile.sv
// Directed bench for spu_writeback_regfile: a register-array model checked every cycle plus literal spot checks.
module tb_spu_writeback_regfile;
  localparam int DW   = 128;
  localparam int AW   = 7;
  localparam int NR   = 6;
  localparam int CW   = 32;
  localparam int NREG = 128;
  localparam int SCW  = 3;

  localparam logic [DW-1:0] C_DEAD = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spu_writeback_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW))  bus ();
  spu_writeback_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(SCW)) bus_s ();

  spu_writeback_regfile #(.NUM_REGS(NREG), .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .wb_if (bus.slave)
  );

  // Narrow-counter twin sees identical traffic so counter wrap is reachable quickly.
  spu_writeback_regfile #(.NUM_REGS(NREG), .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(SCW)) dut_s (
    .clk   (clk),
    .reset (reset),
    .wb_if (bus_s.slave)
  );

  assign bus_s.memToReg_1       = bus.memToReg_1;
  assign bus_s.regWriteEnable_1 = bus.regWriteEnable_1;
  assign bus_s.memReadData_1    = bus.memReadData_1;
  assign bus_s.result_1         = bus.result_1;
  assign bus_s.registerRT_1     = bus.registerRT_1;
  assign bus_s.memToReg_2       = bus.memToReg_2;
  assign bus_s.regWriteEnable_2 = bus.regWriteEnable_2;
  assign bus_s.memReadData_2    = bus.memReadData_2;
  assign bus_s.result_2         = bus.result_2;
  assign bus_s.registerRT_2     = bus.registerRT_2;
  assign bus_s.rd_addr          = bus.rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: architectural register array updated in program order, reads see post-write state.
  logic [DW-1:0]          m_regs [NREG];
  logic [NR-1:0][DW-1:0]  m_rd;
  int unsigned            m_cnt1;
  int unsigned            m_cnt2;
  bit                     m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_rd   = '0;
      m_cnt1 = 0;
      m_cnt2 = 0;
      m_live = 1'b1;
    end else begin
      if (bus.regWriteEnable_1) begin
        m_regs[bus.registerRT_1] = bus.memToReg_1 ? bus.memReadData_1 : bus.result_1;
        m_cnt1 = m_cnt1 + 1;
      end
      if (bus.regWriteEnable_2) begin
        m_regs[bus.registerRT_2] = bus.memToReg_2 ? bus.memReadData_2 : bus.result_2;
        m_cnt2 = m_cnt2 + 1;
      end
      for (int k = 0; k < NR; k++) m_rd[k] = m_regs[bus.rd_addr[k]];
    end
  end

  always @(posedge clk) begin
    if (m_live) begin
      #2;
      for (int k = 0; k < NR; k++)
        chk($sformatf("rd_data_%0d", k), bus.rd_data[k], m_rd[k]);
      chk("wb_data_1", bus.wb_data_1, bus.memToReg_1 ? bus.memReadData_1 : bus.result_1);
      chk("wb_data_2", bus.wb_data_2, bus.memToReg_2 ? bus.memReadData_2 : bus.result_2);
      chk("wb_count_1", DW'(bus.wb_count_1), DW'(m_cnt1));
      chk("wb_count_2", DW'(bus.wb_count_2), DW'(m_cnt2));
      chk("wb_count_1_narrow", DW'(bus_s.wb_count_1), DW'(m_cnt1 % (1 << SCW)));
      chk("wb_count_2_narrow", DW'(bus_s.wb_count_2), DW'(m_cnt2 % (1 << SCW)));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.memToReg_1 = 1'b0; bus.regWriteEnable_1 = 1'b0; bus.memReadData_1 = '0; bus.result_1 = '0; bus.registerRT_1 = '0;
    bus.memToReg_2 = 1'b0; bus.regWriteEnable_2 = 1'b0; bus.memReadData_2 = '0; bus.result_2 = '0; bus.registerRT_2 = '0;
  endtask

  task automatic wr1(input logic [AW-1:0] rt, input logic m2r, input logic [DW-1:0] mem, input logic [DW-1:0] res);
    bus.regWriteEnable_1 = 1'b1; bus.registerRT_1 = rt; bus.memToReg_1 = m2r;
    bus.memReadData_1 = mem; bus.result_1 = res;
  endtask

  task automatic wr2(input logic [AW-1:0] rt, input logic m2r, input logic [DW-1:0] mem, input logic [DW-1:0] res);
    bus.regWriteEnable_2 = 1'b1; bus.registerRT_2 = rt; bus.memToReg_2 = m2r;
    bus.memReadData_2 = mem; bus.result_2 = res;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.rd_addr = '0;
    tick(); tick();
    reset = 1'b0;

    // Every index reads zero after reset.
    for (int i = 0; i < NREG; i++) begin
      bus.rd_addr[0] = AW'(i);
      tick();
    end
    chk("reset_rd0_last", bus.rd_data[0], '0);
    chk("reset_cnt1", DW'(bus.wb_count_1), '0);
    chk("reset_cnt2", DW'(bus.wb_count_2), '0);

    // Pipe 1 ALU-result write, read back one edge later.
    wr1(7'd5, 1'b0, 128'h1111, C_DEAD);
    tick();
    idle();
    bus.rd_addr[0] = 7'd5;
    tick();
    chk("p1_write_rd0", bus.rd_data[0], C_DEAD);
    chk("p1_write_cnt1", DW'(bus.wb_count_1), 128'd1);

    // Pipe 2 load-path write with same-edge read bypass.
    wr2(7'd9, 1'b1, 128'h1234, 128'hFFFF);
    bus.rd_addr[3] = 7'd9;
    #1;
    chk("p2_wb_data_load", bus.wb_data_2, 128'h1234);
    tick();
    idle();
    chk("p2_bypass_rd3", bus.rd_data[3], 128'h1234);

    // Both pipes hit index 20: pipe 2 value is the survivor.
    wr1(7'd20, 1'b0, '0, 128'hAAAA);
    wr2(7'd20, 1'b0, '0, 128'hBBBB);
    bus.rd_addr[1] = 7'd20;
    tick();
    idle();
    chk("collide_bypass_rd1", bus.rd_data[1], 128'hBBBB);
    chk("collide_cnt1", DW'(bus.wb_count_1), 128'd2);
    chk("collide_cnt2", DW'(bus.wb_count_2), 128'd2);
    tick();
    chk("collide_later_rd1", bus.rd_data[1], 128'hBBBB);

    // Disabled write: wb_data still follows inputs, nothing commits.
    bus.registerRT_1 = 7'd7; bus.result_1 = 128'h77;
    bus.rd_addr[2] = 7'd7;
    #1;
    chk("nowrite_wb_data_1", bus.wb_data_1, 128'h77);
    tick();
    idle();
    chk("nowrite_rd2", bus.rd_data[2], '0);
    chk("nowrite_cnt1", DW'(bus.wb_count_1), 128'd2);

    // Read before write returns old value; read on the write edge returns new.
    bus.rd_addr[4] = 7'd5;
    tick();
    chk("old_before_write_rd4", bus.rd_data[4], C_DEAD);
    wr1(7'd5, 1'b0, '0, 128'h5555);
    tick();
    idle();
    chk("write_first_rd4", bus.rd_data[4], 128'h5555);

    // Index 0 is an ordinary register.
    wr2(7'd0, 1'b0, '0, 128'h1);
    tick();
    idle();
    bus.rd_addr[5] = 7'd0;
    tick();
    chk("reg0_rd5", bus.rd_data[5], 128'h1);

    // Streaming writes on both pipes; the narrow counters wrap along the way.
    for (int i = 0; i < 16; i++) begin
      wr1(AW'(32 + i), 1'b0, '0, {32'(i), 32'hC0DE_0001, 32'(i * 3), 32'hFEED});
      wr2(AW'(64 + i), 1'b1, {96'h0, 32'(i * 7 + 1)}, '1);
      for (int k = 0; k < NR; k++)
        bus.rd_addr[k] = (k < 3) ? AW'(32 + ((i + k) % 16)) : AW'(64 + ((i + k) % 16));
      tick();
    end
    idle();
    bus.rd_addr[0] = 7'd33;
    bus.rd_addr[3] = 7'd66;
    tick();
    chk("stream_rd0", bus.rd_data[0], {32'd1, 32'hC0DE_0001, 32'd3, 32'hFEED});
    chk("stream_rd3", bus.rd_data[3], 128'd15);
    chk("stream_cnt1", DW'(bus.wb_count_1), 128'd19);
    chk("stream_cnt1_wrap", DW'(bus_s.wb_count_1), 128'd3);

    // Reset discards the writes presented with it.
    wr1(7'd3, 1'b0, '0, 128'h33);
    tick();
    reset = 1'b1;
    wr1(7'd3, 1'b0, '0, 128'h99);
    wr2(7'd3, 1'b1, 128'h98, '0);
    bus.rd_addr = '0;
    bus.rd_addr[0] = 7'd3;
    tick();
    reset = 1'b0;
    idle();
    for (int k = 0; k < NR; k++)
      chk($sformatf("reset_mid_rd%0d", k), bus.rd_data[k], '0);
    chk("reset_mid_cnt1", DW'(bus.wb_count_1), '0);
    chk("reset_mid_cnt2", DW'(bus.wb_count_2), '0);
    tick();
    chk("reset_mid_reg3", bus.rd_data[0], '0);
    wr1(7'd3, 1'b0, '0, 128'h42);
    tick();
    idle();
    chk("post_reset_write_rd0", bus.rd_data[0], 128'h42);
    chk("post_reset_cnt1", DW'(bus.wb_count_1), 128'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spu_writeback_regfile.md
# spu_writeback_regfile

Writeback end of the dual-pipe SPU datapath: consumes the two per-pipe MEM/WB register outputs, selects load data or ALU result, and commits them into the 128-entry × 128-bit unified register file. Provides registered read ports for the decode/register-fetch stage, with same-cycle write bypass, and per-pipe writeback counters. Sits at the tail of both pipes; pipe 2 is later in program order than pipe 1.

## Interface
- NUM_REGS, 128, register file depth
- DATA_W, 128, register width in bits
- ADDR_W, 7, register index width
- NUM_RD, 6, read ports; ports 0–2 serve pipe 1 operands RA/RB/RC, ports 3–5 serve pipe 2
- CNT_W, 32, writeback counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- memToReg_1  in  1  pipe 1: 1 selects memReadData_1, 0 selects result_1
- regWriteEnable_1  in  1  pipe 1 write request
- memReadData_1  in  DATA_W  pipe 1 load data
- result_1  in  DATA_W  pipe 1 execute result
- registerRT_1  in  ADDR_W  pipe 1 destination index
- memToReg_2, regWriteEnable_2, memReadData_2, result_2, registerRT_2  in  1/1/DATA_W/DATA_W/ADDR_W  pipe 2 equivalents
- rd_addr_k  in  ADDR_W  read index, k = 0..NUM_RD-1
- rd_data_k  out  DATA_W  registered read data, k = 0..NUM_RD-1
- wb_data_1, wb_data_2  out  DATA_W  combinational selected writeback value per pipe (forwarding source)
- wb_count_1, wb_count_2  out  CNT_W  number of committed writes per pipe

## Operation
- wb_data_p = memToReg_p ? memReadData_p : result_p; purely combinational, independent of regWriteEnable_p and reset.
- Write p commits on the edge where regWriteEnable_p = 1 and reset = 0: regs[registerRT_p] <= wb_data_p.
- Both pipes write the same index on the same edge: pipe 2 value stored (program order); both counters still increment.
- No hardwired-zero register; index 0 is an ordinary register.
- Read port k on every non-reset edge: rd_data_k <= bypassed value of rd_addr_k, where bypass priority is pipe 2 write (enabled, index match) > pipe 1 write (enabled, index match) > regs[rd_addr_k].
- Result: rd_data_k always equals the register contents after that edge's writes.
- Multiple ports may read the same index; no port conflicts.
- wb_count_p increments by 1 on each edge where regWriteEnable_p = 1 and reset = 0; wraps from 2^CNT_W−1 to 0.
- reset = 1 on an edge: all regs, all rd_data_k, both wb_count_p cleared to 0; any write or read requested on that edge is discarded.

## Timing
- Write latency: value presented at edge N visible in regs after edge N.
- Read latency: 1 cycle; rd_addr_k sampled at edge N, rd_data_k valid from edge N until edge N+1.
- Read of index written at same edge N returns the new value (write-first); no stall required.
- Read of index written at edge N+1 while rd_addr applied at edge N returns the old value.
- wb_data_p: zero-cycle combinational path.
- Reset values: regs = 0, rd_data_k = 0, wb_count_1 = wb_count_2 = 0; wb_data_p follows inputs.
- Reset mid-stream: first write after deassertion commits on first edge with reset = 0; counters restart from 0.
- Inputs must be stable around rising edge; no other handshake — every enabled write is accepted unconditionally.

## Test plan
- Reset, then read all 128 indices on port 0 -> rd_data_0 = 0 each cycle; wb_count_1 = wb_count_2 = 0.
- Pipe 1 write RT=5, memToReg=0, result=0xDEAD…01 at edge 1; port 0 reads 5 from edge 2 -> rd_data_0 = 0xDEAD…01 after edge 2; wb_count_1 = 1.
- Pipe 2 write RT=9, memToReg=1, memReadData=0x1234, result=0xFFFF at edge N with rd_addr_3 = 9 same edge -> rd_data_3 = 0x1234 after edge N (bypass, load path selected).
- Both pipes write RT=20 at edge N (pipe 1 = 0xAAAA, pipe 2 = 0xBBBB), port 1 reads 20 same edge -> rd_data_1 = 0xBBBB; later read also 0xBBBB; both counters +1.
- Pipe 1 regWriteEnable=0, RT=7, result=0x77 -> regs[7] unchanged, wb_count_1 unchanged, wb_data_1 = 0x77.
- Preload wb_count_1 to 0xFFFFFFFF via 2^32−1 writes (or forced), one more write -> wb_count_1 = 0; assert reset with pending writes to RT=3 -> regs[3] = 0, all outputs 0 next cycle.
